// File: rtl/snn_pkg.sv
// Shared spiking-network types, constants and the saturating-add helper.
// Used by spike_synapse and by the downstream lif neuron.
package snn_pkg;

  typedef enum logic {LOAD, RUN} syn_state_t;

  localparam int CUR_W   = 8;
  localparam int CUR_MAX = (1 << CUR_W) - 1;
  localparam int ACC_W   = 16;

  typedef logic [CUR_W-1:0]        cur_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  // a + b clamped to [0, CUR_MAX]
  function automatic cur_t sat_add(
    input cur_t a,
    input acc_t b
  );
    acc_t s;
    s = acc_t'(a) + b;
    if (s < 0)
      return '0;
    if (s > acc_t'(CUR_MAX))
      return cur_t'(CUR_MAX);
    return s[CUR_W-1:0];
  endfunction

endpackage

// File: rtl/spike_synapse_if.sv
// Weight-load byte stream: valid/ready plus restart and done strobes.
// Master drives start/valid/data; the synapse is the slave.
interface spike_synapse_if #(
  parameter int W_WIDTH = 8
);
  logic               start;
  logic               valid;
  logic [W_WIDTH-1:0] data;
  logic               ready;
  logic               done;

  modport master (
    output start, valid, data,
    input  ready, done
  );

  modport slave (
    input  start, valid, data,
    output ready, done
  );
endinterface

// File: rtl/syn_leak_sat.sv
// Leak, add and clamp datapath: (current, sum) -> next current.
// SPIKE_SYNAPSE_SIGNED_W_EN makes sum two's complement.
module syn_leak_sat
  import snn_pkg::*;
#(
  parameter int SUM_W       = 11,
  parameter int DECAY_SHIFT = 1
) (
  input  cur_t cur,
`ifdef SPIKE_SYNAPSE_SIGNED_W_EN
  input  logic signed [SUM_W-1:0] sum,
`else
  input  logic [SUM_W-1:0] sum,
`endif
  output cur_t nxt
);

  cur_t dec;

  always_comb begin
    dec = cur >> DECAY_SHIFT;
    // small currents still leak so they always reach zero
    if (cur != '0 && dec == '0)
      dec = cur_t'(1);
    nxt = sat_add(cur - dec, acc_t'(sum));
  end

endmodule

// File: rtl/spike_synapse.sv
// Weighted, leaky, saturating synaptic current feeding a lif neuron.
// SPIKE_SYNAPSE_SIGNED_W_EN: signed (inhibitory) weights, clamp at 0.
module spike_synapse
  import snn_pkg::*;
#(
  parameter int N_IN        = 4,
  parameter int W_WIDTH     = 8,
  parameter int CUR_WIDTH   = CUR_W,
  parameter int DECAY_SHIFT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [N_IN-1:0]      spike_in,
  spike_synapse_if.slave       wload,
  output logic [CUR_WIDTH-1:0] current,
  output logic                 busy
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int SUM_W = W_WIDTH + $clog2(N_IN) + 1;

  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t LAST = idx_t'(N_IN - 1);

`ifdef SPIKE_SYNAPSE_SIGNED_W_EN
  typedef logic signed [SUM_W-1:0] sum_t;
  function automatic sum_t ext(input logic [W_WIDTH-1:0] w);
    return sum_t'($signed(w));
  endfunction
`else
  typedef logic [SUM_W-1:0] sum_t;
  function automatic sum_t ext(input logic [W_WIDTH-1:0] w);
    return sum_t'(w);
  endfunction
`endif

  syn_state_t         state_q, state_d;
  idx_t               idx_q, idx_d;
  logic [W_WIDTH-1:0] w_q [N_IN];
  logic [W_WIDTH-1:0] w_d [N_IN];
  cur_t               cur_q, cur_d, cur_nxt;
  logic               done_q, done_d;
  logic               start, accept;
  sum_t               sum;

  assign wload.ready = ena && (state_q == LOAD);
  assign wload.done  = ena && done_q;
  assign busy        = (state_q == LOAD);
  assign current     = cur_q;

  always_comb begin
    sum = '0;
    if (state_q == RUN)
      for (int i = 0; i < N_IN; i++)
        if (spike_in[i])
          sum = sum + ext(w_q[i]);
  end

  syn_leak_sat #(
    .SUM_W       (SUM_W),
    .DECAY_SHIFT (DECAY_SHIFT)
  ) u_leak_sat (
    .cur (cur_q),
    .sum (sum),
    .nxt (cur_nxt)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    w_d     = w_q;
    cur_d   = cur_q;
    done_d  = done_q;
    start   = ena && wload.start;
    // a restart drops any byte offered in the same cycle
    accept  = wload.valid && wload.ready && !start;
    if (ena) begin
      cur_d  = cur_nxt;
      done_d = 1'b0;
      unique case (1'b1)
        start: begin
          state_d = LOAD;
          idx_d   = '0;
        end
        accept: begin
          w_d[idx_q] = wload.data;
          if (idx_q == LAST) begin
            state_d = RUN;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      idx_q   <= '0;
      cur_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < N_IN; i++)
        w_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cur_q   <= cur_d;
      done_q  <= done_d;
      w_q     <= w_d;
    end
  end

endmodule

// File: tb/tb_spike_synapse.sv
// Self-checking bench for spike_synapse against an integer model.
// Also covers the SPIKE_SYNAPSE_SIGNED_W_EN build.
module tb_spike_synapse;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [3:0] spike_in = '0;
  logic [7:0] cur;
  logic       busy;

  int checks = 0;
  int errors = 0;

  spike_synapse_if #(.W_WIDTH(8)) wl ();

  spike_synapse dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .spike_in (spike_in),
    .wload    (wl),
    .current  (cur),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // reference model state
  bit m_load;
  int m_idx;
  int m_w[4];
  int m_cur;
  bit m_done;

  function automatic int wdec(input logic [7:0] d);
`ifdef SPIKE_SYNAPSE_SIGNED_W_EN
    return int'($signed(d));
`else
    return int'(d);
`endif
  endfunction

  task automatic model_reset();
    m_load = 1'b1;
    m_idx  = 0;
    m_cur  = 0;
    m_done = 1'b0;
    for (int i = 0; i < 4; i++)
      m_w[i] = 0;
  endtask

  // one clock: predict from current inputs, then cross the edge
  task automatic tick();
    int dec, sum, nxt, idx_n;
    bit load_n, done_n;
    int w_n[4];
    load_n = m_load;
    idx_n  = m_idx;
    done_n = m_done;
    nxt    = m_cur;
    w_n    = m_w;
    if (ena) begin
      dec = m_cur / 2;
      if (m_cur != 0 && dec == 0)
        dec = 1;
      sum = 0;
      if (!m_load)
        for (int i = 0; i < 4; i++)
          if (spike_in[i])
            sum += m_w[i];
      nxt = m_cur - dec + sum;
      if (nxt < 0)
        nxt = 0;
      if (nxt > 255)
        nxt = 255;
      done_n = 1'b0;
      if (wl.start) begin
        load_n = 1'b1;
        idx_n  = 0;
      end else if (wl.valid && m_load) begin
        w_n[m_idx] = wdec(wl.data);
        if (m_idx == 3) begin
          load_n = 1'b0;
          idx_n  = 0;
          done_n = 1'b1;
        end else begin
          idx_n = m_idx + 1;
        end
      end
    end
    @(posedge clk);
    #1;
    m_load = load_n;
    m_idx  = idx_n;
    m_done = done_n;
    m_cur  = nxt;
    m_w    = w_n;
  endtask

  task automatic test_reset();
    ena      = 1'b1;
    spike_in = '0;
    rst_n    = 1'b0;
    #3;
    checks++;
    if (cur !== 8'd0 || busy !== 1'b1 || wl.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals cur=%0d busy=%0b done=%0b want 0/1/0",
               cur, busy, wl.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    checks++;
    if (wl.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %0b want 1", wl.ready);
    end
    spike_in = 4'b1111;
    repeat (3) begin
      tick();
      checks++;
      if (cur !== 8'd0) begin
        errors++;
        $display("FAIL load_no_sum cur=%0d want 0", cur);
      end
    end
    spike_in = '0;
  endtask

  task automatic test_load_leak();
    int wv[4];
    int seq[6];
    wv  = '{10, 20, 30, 40};
    seq = '{10, 5, 3, 2, 1, 0};
    wl.valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wl.data = 8'(wv[i]);
      checks++;
      if (wl.ready !== 1'b1) begin
        errors++;
        $display("FAIL load_ready[%0d] got %0b want 1", i, wl.ready);
      end
      tick();
    end
    wl.valid = 1'b0;
    checks++;
    if (wl.done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL load_done done=%0b busy=%0b want 1/0",
               wl.done, busy);
    end
    spike_in = 4'b0001;
    tick();
    spike_in = '0;
    checks++;
    if (wl.done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse got %0b want 0", wl.done);
    end
    for (int k = 0; k < 6; k++) begin
      if (k > 0)
        tick();
      checks++;
      if (cur !== 8'(seq[k]) || m_cur != seq[k]) begin
        errors++;
        $display("FAIL leak[%0d] cur=%0d want %0d", k, cur, seq[k]);
      end
    end
  endtask

  task automatic test_saturation();
    int rel[9];
    rel = '{128, 64, 32, 16, 8, 4, 2, 1, 0};
    wl.start = 1'b1;
    tick();
    wl.start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_busy got %0b want 1", busy);
    end
    wl.valid = 1'b1;
    wl.data  = 8'd100;
    repeat (4) tick();
    wl.valid = 1'b0;
    spike_in = 4'b1111;
    repeat (5) begin
      tick();
      checks++;
      if (cur !== 8'd255) begin
        errors++;
        $display("FAIL sat_hold cur=%0d want 255", cur);
      end
    end
    spike_in = '0;
    for (int k = 0; k < 9; k++) begin
      tick();
      checks++;
      if (cur !== 8'(rel[k])) begin
        errors++;
        $display("FAIL sat_release[%0d] cur=%0d want %0d",
                 k, cur, rel[k]);
      end
    end
  endtask

  task automatic test_ena_stall();
    spike_in = 4'b1111;
    tick();
    spike_in = '0;
    wl.start = 1'b1;
    tick();
    wl.start = 1'b0;
    wl.valid = 1'b1;
    wl.data  = 8'd7;
    tick();
    wl.data  = 8'd8;
    tick();
    wl.data  = 8'd9;
    ena = 1'b0;
    #1;
    checks++;
    if (wl.ready !== 1'b0 || wl.done !== 1'b0) begin
      errors++;
      $display("FAIL stall_ready ready=%0b done=%0b want 0/0",
               wl.ready, wl.done);
    end
    spike_in = 4'b1111;
    repeat (3) tick();
    spike_in = '0;
    checks++;
    if (cur !== 8'd32 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stall_freeze cur=%0d busy=%0b want 32/1",
               cur, busy);
    end
    ena = 1'b1;
    tick();
    wl.data = 8'd10;
    tick();
    wl.valid = 1'b0;
    checks++;
    if (wl.done !== 1'b1 || cur !== 8'd8) begin
      errors++;
      $display("FAIL stall_done done=%0b cur=%0d want 1/8",
               wl.done, cur);
    end
    spike_in = 4'b0100;
    tick();
    spike_in = '0;
    checks++;
    if (cur !== 8'd13 || m_cur != 13) begin
      errors++;
      $display("FAIL stall_index cur=%0d want 13", cur);
    end
  endtask

  task automatic test_reload();
    int seq[6];
    seq = '{20, 10, 5, 3, 2, 11};
    wl.start = 1'b1;
    tick();
    wl.start = 1'b0;
    wl.valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wl.data = 8'(10 * i);
      tick();
    end
    wl.valid = 1'b0;
    repeat (8) tick();
    spike_in = 4'b1000;
    tick();
    spike_in = '0;
    checks++;
    if (cur !== 8'd40) begin
      errors++;
      $display("FAIL reload_pre cur=%0d want 40", cur);
    end
    wl.start = 1'b1;
    tick();
    wl.start = 1'b0;
    checks++;
    if (busy !== 1'b1 || cur !== 8'(seq[0])) begin
      errors++;
      $display("FAIL reload_start busy=%0b cur=%0d want 1/20",
               busy, cur);
    end
    spike_in = 4'b1111;
    wl.valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wl.data = 8'(i);
      tick();
      checks++;
      if (cur !== 8'(seq[i])) begin
        errors++;
        $display("FAIL reload_ignore[%0d] cur=%0d want %0d",
                 i, cur, seq[i]);
      end
    end
    wl.valid = 1'b0;
    tick();
    spike_in = '0;
    checks++;
    if (cur !== 8'(seq[5])) begin
      errors++;
      $display("FAIL reload_new cur=%0d want %0d", cur, seq[5]);
    end
  endtask

  task automatic test_async_reset();
    spike_in = 4'b1111;
    tick();
    spike_in = '0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (cur !== 8'd0 || busy !== 1'b1 || wl.done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset cur=%0d busy=%0b done=%0b want 0/1/0",
               cur, busy, wl.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    checks++;
    if (wl.ready !== 1'b1) begin
      errors++;
      $display("FAIL async_ready got %0b want 1", wl.ready);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      ena      = ($urandom_range(0, 7) != 0);
      spike_in = 4'($urandom);
      wl.start = ($urandom_range(0, 23) == 0);
      wl.valid = ($urandom_range(0, 2) != 0);
      wl.data  = 8'($urandom);
      tick();
      checks++;
      if (cur !== 8'(m_cur) || busy !== m_load ||
          wl.ready !== (m_load && ena) ||
          wl.done !== (m_done && ena)) begin
        errors++;
        $display("FAIL random[%0d] cur=%0d busy=%0b rdy=%0b done=%0b want %0d/%0b/%0b/%0b",
                 n, cur, busy, wl.ready, wl.done, m_cur, m_load,
                 m_load && ena, m_done && ena);
      end
    end
    ena      = 1'b1;
    spike_in = '0;
    wl.start = 1'b0;
    wl.valid = 1'b0;
  endtask

`ifdef SPIKE_SYNAPSE_SIGNED_W_EN
  task automatic test_signed();
    logic [7:0] wv[4];
    wv = '{8'hCE, 8'd30, 8'd0, 8'd0};
    wl.start = 1'b1;
    tick();
    wl.start = 1'b0;
    wl.valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wl.data = wv[i];
      tick();
    end
    wl.valid = 1'b0;
    repeat (10) tick();
    spike_in = 4'b0010;
    tick();
    checks++;
    if (cur !== 8'd30) begin
      errors++;
      $display("FAIL signed_pre cur=%0d want 30", cur);
    end
    spike_in = 4'b0001;
    tick();
    spike_in = '0;
    checks++;
    if (cur !== 8'd0 || m_cur != 0) begin
      errors++;
      $display("FAIL signed_clamp cur=%0d want 0", cur);
    end
  endtask
`endif

  initial begin
    wl.start = 1'b0;
    wl.valid = 1'b0;
    wl.data  = '0;
    model_reset();
    test_reset();
    test_load_leak();
    test_saturation();
    test_ena_stall();
    test_reload();
    test_async_reset();
    test_random();
`ifdef SPIKE_SYNAPSE_SIGNED_W_EN
    test_signed();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
